// File: rtl/haar_pkg.sv
// rtl/haar_pkg.sv - shared widths, word offsets, FSM states and rectangle helper for the Haar stage evaluator
package haar_pkg;
   localparam int DATA_WIDTH_12            = 12;
   localparam int DATA_WIDTH_8             = 8;
   localparam int SUM_WIDTH                = 20;
   localparam int ACC_WIDTH                = 40;
   localparam int NUM_PARAM_PER_CLASSIFIER = 18;
   localparam int NUM_STAGE_THRESHOLD      = 3;
   localparam int VAR_WIDTH                = 16;
   localparam int NODE_THR_WIDTH           = 28;

   localparam int RECT_STRIDE  = 5;
   localparam int OFF_X        = 0;
   localparam int OFF_Y        = 1;
   localparam int OFF_W        = 2;
   localparam int OFF_H        = 3;
   localparam int OFF_WEIGHT   = 4;
   localparam int OFF_NODE_THR = 15;
   localparam int OFF_LEFT     = 16;
   localparam int OFF_RIGHT    = 17;
   localparam int LAST_WORD    = NUM_PARAM_PER_CLASSIFIER - 1;

   localparam logic [1:0] RECT_NONE = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_REQ,
      ST_WAIT,
      ST_NODE,
      ST_DECIDE
   } haar_state_t;

   // Lowest rectangle index >= from whose weight is nonzero; RECT_NONE when none remain.
   function automatic logic [1:0] next_rect(input logic [1:0] from, input logic [2:0] nz);
      logic [1:0] r;
      r = RECT_NONE;
      for (int i = 2; i >= 0; i--) begin
         if (i >= int'(from) && nz[i]) r = 2'(i);
      end
      return r;
   endfunction
endpackage

// File: rtl/haar_feature_mac.sv
// rtl/haar_feature_mac.sv - signed weight times unsigned rectangle sum, accumulated into a registered feature value
module haar_feature_mac
   import haar_pkg::*;
(
   input  logic                            clk_fpga,
   input  logic                            reset_fpga,
   input  logic                            clear,
   input  logic                            enable,
   input  logic signed [DATA_WIDTH_12-1:0] weight,
   input  logic [SUM_WIDTH-1:0]            rect_sum,
   output logic signed [ACC_WIDTH-1:0]     acc
);
   localparam int PROD_WIDTH = DATA_WIDTH_12 + SUM_WIDTH + 1;

   logic signed [PROD_WIDTH-1:0] weight_ext;
   logic signed [PROD_WIDTH-1:0] sum_ext;
   logic signed [PROD_WIDTH-1:0] prod;

   // The sum is unsigned, so it is zero-extended before entering the signed multiply.
   assign weight_ext = PROD_WIDTH'(weight);
   assign sum_ext    = $signed(PROD_WIDTH'(rect_sum));
   assign prod       = weight_ext * sum_ext;

   always_ff @(posedge clk_fpga or posedge reset_fpga) begin
      if (reset_fpga) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (enable) begin
         acc <= acc + {{(ACC_WIDTH-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
      end
   end
endmodule

// File: rtl/haar_stage_evaluator.sv
// rtl/haar_stage_evaluator.sv - evaluates one cascade stage for the current window from its parameter word stream
module haar_stage_evaluator
   import haar_pkg::*;
(
   input  logic                        clk_fpga,
   input  logic                        reset_fpga,
   input  logic                        i_start,
   input  logic [VAR_WIDTH-1:0]        i_var_norm,
   input  logic                        i_valid,
   output logic                        o_ready,
   input  logic [DATA_WIDTH_12-1:0]    i_data,
   input  logic                        i_end_single,
   input  logic                        i_end_database,
   output logic                        o_rect_req,
   output logic [DATA_WIDTH_8-1:0]     o_rect_x,
   output logic [DATA_WIDTH_8-1:0]     o_rect_y,
   output logic [DATA_WIDTH_8-1:0]     o_rect_w,
   output logic [DATA_WIDTH_8-1:0]     o_rect_h,
   input  logic                        i_rect_valid,
   input  logic [SUM_WIDTH-1:0]        i_rect_sum,
   output logic                        o_done,
   output logic                        o_pass,
   output logic [ACC_WIDTH-1:0]        o_stage_sum,
   output logic                        o_err
);
   haar_state_t                   state;
   logic [DATA_WIDTH_12-1:0]      param [NUM_PARAM_PER_CLASSIFIER];
   logic [4:0]                    cnt;
   logic [1:0]                    rect_idx;
   logic [VAR_WIDTH-1:0]          var_norm;
   logic signed [ACC_WIDTH-1:0]   stage_sum;
   logic                          db_bad;

   logic [2:0]                    nz;
   logic [1:0]                    rect_first;
   logic [1:0]                    rect_after;
   logic [DATA_WIDTH_12-1:0]      rx, ry, rw, rh, rwt;
   logic signed [ACC_WIDTH-1:0]   feat;
   logic                          mac_clear;
   logic                          mac_en;
   logic signed [NODE_THR_WIDTH-1:0] node_thr;
   logic signed [ACC_WIDTH-1:0]   node_thr_ext;
   logic [DATA_WIDTH_12-1:0]      leaf;
   logic signed [ACC_WIDTH-1:0]   leaf_ext;
   logic signed [ACC_WIDTH-1:0]   stage_thr_ext;

   assign o_ready = (state == ST_LOAD);

   assign nz = {|param[2*RECT_STRIDE+OFF_WEIGHT],
                |param[RECT_STRIDE+OFF_WEIGHT],
                |param[OFF_WEIGHT]};
   assign rect_first = next_rect(2'd0, nz);
   assign rect_after = next_rect(rect_idx + 2'd1, nz);

   always_comb begin
      rx  = param[OFF_X];
      ry  = param[OFF_Y];
      rw  = param[OFF_W];
      rh  = param[OFF_H];
      rwt = param[OFF_WEIGHT];
      case (rect_idx)
         2'd1: begin
            rx  = param[RECT_STRIDE+OFF_X];
            ry  = param[RECT_STRIDE+OFF_Y];
            rw  = param[RECT_STRIDE+OFF_W];
            rh  = param[RECT_STRIDE+OFF_H];
            rwt = param[RECT_STRIDE+OFF_WEIGHT];
         end
         2'd2: begin
            rx  = param[2*RECT_STRIDE+OFF_X];
            ry  = param[2*RECT_STRIDE+OFF_Y];
            rw  = param[2*RECT_STRIDE+OFF_W];
            rh  = param[2*RECT_STRIDE+OFF_H];
            rwt = param[2*RECT_STRIDE+OFF_WEIGHT];
         end
         default: ;
      endcase
   end

   // An abort must also flush a partially accumulated feature.
   assign mac_clear = i_start || (state == ST_NODE);
   assign mac_en    = (state == ST_WAIT) && i_rect_valid;

   haar_feature_mac u_mac (
      .clk_fpga   (clk_fpga),
      .reset_fpga (reset_fpga),
      .clear      (mac_clear),
      .enable     (mac_en),
      .weight     ($signed(rwt)),
      .rect_sum   (i_rect_sum),
      .acc        (feat)
   );

   // The node threshold scales with window variance; 12b x 16b always fits the 28-bit product.
   assign node_thr     = NODE_THR_WIDTH'($signed(param[OFF_NODE_THR])) *
                         $signed(NODE_THR_WIDTH'(var_norm));
   assign node_thr_ext = {{(ACC_WIDTH-NODE_THR_WIDTH){node_thr[NODE_THR_WIDTH-1]}}, node_thr};
   assign leaf         = (feat < node_thr_ext) ? param[OFF_LEFT] : param[OFF_RIGHT];
   assign leaf_ext     = {{(ACC_WIDTH-DATA_WIDTH_12){leaf[DATA_WIDTH_12-1]}}, leaf};

   assign stage_thr_ext = {{(ACC_WIDTH-3*DATA_WIDTH_12){param[0][DATA_WIDTH_12-1]}},
                           param[0], param[1], param[2]};

   always_ff @(posedge clk_fpga or posedge reset_fpga) begin
      if (reset_fpga) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         rect_idx    <= '0;
         var_norm    <= '0;
         stage_sum   <= '0;
         db_bad      <= 1'b0;
         o_rect_req  <= 1'b0;
         o_rect_x    <= '0;
         o_rect_y    <= '0;
         o_rect_w    <= '0;
         o_rect_h    <= '0;
         o_done      <= 1'b0;
         o_pass      <= 1'b0;
         o_stage_sum <= '0;
         o_err       <= 1'b0;
         for (int i = 0; i < NUM_PARAM_PER_CLASSIFIER; i++) param[i] <= '0;
      end else begin
         o_done     <= 1'b0;
         o_rect_req <= 1'b0;
         if (i_start) begin
            state       <= ST_LOAD;
            cnt         <= '0;
            rect_idx    <= '0;
            var_norm    <= i_var_norm;
            stage_sum   <= '0;
            db_bad      <= 1'b0;
            o_pass      <= 1'b0;
            o_stage_sum <= '0;
            o_err       <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: ;
               ST_LOAD: begin
                  if (i_valid) begin
                     param[cnt] <= i_data;
                     if (i_end_database) begin
                        // Only a clean third threshold word makes the stage result trustworthy.
                        if (cnt != 5'(NUM_STAGE_THRESHOLD-1) || i_end_single) begin
                           db_bad <= 1'b1;
                           o_err  <= 1'b1;
                        end
                        state <= ST_DECIDE;
                     end else if (i_end_single && cnt == 5'(LAST_WORD)) begin
                        cnt <= '0;
                        if (rect_first == RECT_NONE) begin
                           state <= ST_NODE;
                        end else begin
                           rect_idx <= rect_first;
                           state    <= ST_REQ;
                        end
                     end else if (i_end_single || cnt == 5'(LAST_WORD)) begin
                        o_err <= 1'b1;
                        cnt   <= '0;
                     end else begin
                        cnt <= cnt + 5'd1;
                     end
                  end
               end
               ST_REQ: begin
                  o_rect_req <= 1'b1;
                  o_rect_x   <= rx[DATA_WIDTH_8-1:0];
                  o_rect_y   <= ry[DATA_WIDTH_8-1:0];
                  o_rect_w   <= rw[DATA_WIDTH_8-1:0];
                  o_rect_h   <= rh[DATA_WIDTH_8-1:0];
                  state      <= ST_WAIT;
               end
               ST_WAIT: begin
                  if (i_rect_valid) begin
                     if (rect_after == RECT_NONE) begin
                        state <= ST_NODE;
                     end else begin
                        rect_idx <= rect_after;
                        state    <= ST_REQ;
                     end
                  end
               end
               ST_NODE: begin
                  stage_sum <= stage_sum + leaf_ext;
                  cnt       <= '0;
                  state     <= ST_LOAD;
               end
               ST_DECIDE: begin
                  o_done      <= 1'b1;
                  o_pass      <= !db_bad && (stage_sum >= stage_thr_ext);
                  o_stage_sum <= stage_sum;
                  state       <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_haar_stage_evaluator.sv
// tb/tb_haar_stage_evaluator.sv - scoreboard bench for haar_stage_evaluator
module tb_haar_stage_evaluator;
   logic        clk_fpga = 1'b0;
   logic        reset_fpga;
   logic        i_start;
   logic [15:0] i_var_norm;
   logic        i_valid;
   logic        o_ready;
   logic [11:0] i_data;
   logic        i_end_single;
   logic        i_end_database;
   logic        o_rect_req;
   logic [7:0]  o_rect_x, o_rect_y, o_rect_w, o_rect_h;
   logic        i_rect_valid;
   logic [19:0] i_rect_sum;
   logic        o_done;
   logic        o_pass;
   logic [39:0] o_stage_sum;
   logic        o_err;

   typedef struct packed {
      logic        pass;
      logic [39:0] sum;
      logic        err;
   } exp_t;

   exp_t        sb [$];
   int          checks = 0;
   int          errors = 0;
   int          fixed_lat = 2;
   logic        stall_en = 1'b0;
   logic [11:0] cw [18];

   haar_stage_evaluator dut (
      .clk_fpga       (clk_fpga),
      .reset_fpga     (reset_fpga),
      .i_start        (i_start),
      .i_var_norm     (i_var_norm),
      .i_valid        (i_valid),
      .o_ready        (o_ready),
      .i_data         (i_data),
      .i_end_single   (i_end_single),
      .i_end_database (i_end_database),
      .o_rect_req     (o_rect_req),
      .o_rect_x       (o_rect_x),
      .o_rect_y       (o_rect_y),
      .o_rect_w       (o_rect_w),
      .o_rect_h       (o_rect_h),
      .i_rect_valid   (i_rect_valid),
      .i_rect_sum     (i_rect_sum),
      .o_done         (o_done),
      .o_pass         (o_pass),
      .o_stage_sum    (o_stage_sum),
      .o_err          (o_err)
   );

   always #5 clk_fpga = ~clk_fpga;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic fail_now(input string nm);
      checks++;
      errors++;
      $display("FAIL %s timed out", nm);
   endtask

   function automatic longint rsum(input logic [7:0] x, y, w, h);
      return longint'(w) * longint'(h) + longint'(x) + longint'(y);
   endfunction

   function automatic longint model_leaf(input longint vn);
      longint f, t;
      f = 0;
      for (int r = 0; r < 3; r++)
         f += longint'($signed(cw[5*r+4])) *
              rsum(cw[5*r][7:0], cw[5*r+1][7:0], cw[5*r+2][7:0], cw[5*r+3][7:0]);
      t = longint'($signed(cw[15])) * vn;
      return (f < t) ? longint'($signed(cw[16])) : longint'($signed(cw[17]));
   endfunction

   task automatic load_directed();
      cw = '{12'd0, 12'd0, 12'd10, 12'd10, 12'd1,
             12'd0, 12'd0, 12'd5,  12'd6,  12'hFFE,
             12'd1, 12'd2, 12'd3,  12'd4,  12'd0,
             12'd10, 12'hFFB, 12'd7};
   endtask

   task automatic send_word(input logic [11:0] d, input logic es, input logic ed);
      int t;
      if (stall_en) repeat ($urandom_range(0, 2)) begin @(posedge clk_fpga); #1; end
      i_valid = 1'b1; i_data = d; i_end_single = es; i_end_database = ed;
      t = 0;
      forever begin
         @(negedge clk_fpga);
         if (o_ready) break;
         t++;
         if (t > 300) begin fail_now("word_accept"); break; end
      end
      @(posedge clk_fpga); #1;
      i_valid = 1'b0; i_end_single = 1'b0; i_end_database = 1'b0;
   endtask

   task automatic send_cls(input int end_at);
      for (int k = 0; k < 18; k++) begin
         send_word(cw[k], k == end_at, 1'b0);
         if (k == end_at) break;
      end
   endtask

   task automatic send_thr(input logic [35:0] tv, input int n);
      logic [11:0] wd [3];
      wd[0] = tv[35:24]; wd[1] = tv[23:12]; wd[2] = tv[11:0];
      for (int k = 0; k < n; k++) send_word(wd[k], 1'b0, k == n - 1);
   endtask

   task automatic do_start(input logic [15:0] vn);
      i_start = 1'b1; i_var_norm = vn;
      @(posedge clk_fpga); #1;
      i_start = 1'b0;
   endtask

   task automatic wait_sb();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 500) begin @(posedge clk_fpga); t++; end
      if (sb.size() != 0) begin fail_now("result_done"); sb.delete(); end
      @(posedge clk_fpga); #1;
   endtask

   // Rectangle-sum responder: sum = w*h + x + y after a fixed or random latency.
   initial begin
      logic [19:0] s;
      int          lat;
      i_rect_valid = 1'b0; i_rect_sum = '0;
      forever begin
         @(negedge clk_fpga);
         if (o_rect_req) begin
            s   = 20'(rsum(o_rect_x, o_rect_y, o_rect_w, o_rect_h));
            lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 8));
            repeat (lat) @(posedge clk_fpga);
            #1; i_rect_valid = 1'b1; i_rect_sum = s;
            @(posedge clk_fpga); #1; i_rect_valid = 1'b0;
         end
      end
   end

   // Result monitor: pops the scoreboard on every o_done.
   initial begin
      exp_t e;
      logic expect_low;
      expect_low = 1'b0;
      forever begin
         @(negedge clk_fpga);
         if (expect_low) begin
            chk("done_one_cycle", o_done, 1'b0);
            expect_low = 1'b0;
         end else if (o_done) begin
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_done actual=1 required=0");
            end else begin
               e = sb.pop_front();
               chk("pass", o_pass, e.pass);
               chk("stage_sum", o_stage_sum, e.sum);
               chk("err", o_err, e.err);
               expect_low = 1'b1;
            end
         end
      end
   end

   initial begin
      longint vn, total, thr;
      int     t;
      reset_fpga = 1'b1; i_start = 1'b0; i_var_norm = '0; i_valid = 1'b0;
      i_data = '0; i_end_single = 1'b0; i_end_database = 1'b0;
      repeat (3) @(posedge clk_fpga);
      @(negedge clk_fpga);
      chk("rst_ready", o_ready, 1'b0);
      chk("rst_done", o_done, 1'b0);
      chk("rst_pass", o_pass, 1'b0);
      chk("rst_sum", o_stage_sum, 40'd0);
      chk("rst_err", o_err, 1'b0);
      chk("rst_req", o_rect_req, 1'b0);
      @(posedge clk_fpga); #1; reset_fpga = 1'b0;
      @(posedge clk_fpga); #1;

      // feat 40 vs node thr 40 -> right (7); stage thr 7 passes, 8 fails
      load_directed();
      do_start(16'd4);
      sb.push_back('{pass: 1'b1, sum: 40'd7, err: 1'b0});
      send_cls(17); send_thr(36'd7, 3); wait_sb();
      do_start(16'd4);
      sb.push_back('{pass: 1'b0, sum: 40'd7, err: 1'b0});
      send_cls(17); send_thr(36'd8, 3); wait_sb();

      // i_end_single on word 12 discards that classifier only
      do_start(16'd4);
      send_cls(12);
      @(negedge clk_fpga); chk("early_end_err", o_err, 1'b1);
      @(posedge clk_fpga); #1;
      sb.push_back('{pass: 1'b1, sum: 40'd7, err: 1'b1});
      send_cls(17); send_thr(36'd7, 3); wait_sb();

      // abort while waiting on a slow rectangle response
      fixed_lat = 8;
      do_start(16'd4);
      send_cls(17);
      t = 0;
      while (!o_rect_req && t < 50) begin @(negedge clk_fpga); t++; end
      if (!o_rect_req) fail_now("rect_req");
      @(posedge clk_fpga); #1; i_start = 1'b1;
      @(posedge clk_fpga); #1; i_start = 1'b0;
      @(negedge clk_fpga);
      chk("abort_ready", o_ready, 1'b1);
      chk("abort_sum", o_stage_sum, 40'd0);
      chk("abort_err", o_err, 1'b0);
      repeat (12) @(posedge clk_fpga);
      #1; fixed_lat = 2;
      sb.push_back('{pass: 1'b1, sum: 40'd7, err: 1'b0});
      send_cls(17); send_thr(36'd7, 3); wait_sb();

      // database ends after only two threshold words
      do_start(16'd4);
      sb.push_back('{pass: 1'b0, sum: 40'd0, err: 1'b1});
      send_thr(36'd7, 2); wait_sb();

      // 32 random classifiers with stalls and random rectangle latency
      stall_en = 1'b1; fixed_lat = 0;
      vn = longint'($urandom_range(0, 60));
      do_start(16'(vn));
      total = 0;
      for (int c = 0; c < 32; c++) begin
         for (int r = 0; r < 3; r++) begin
            cw[5*r]   = 12'($urandom_range(0, 15));
            cw[5*r+1] = 12'($urandom_range(0, 15));
            cw[5*r+2] = 12'($urandom_range(0, 15));
            cw[5*r+3] = 12'($urandom_range(0, 15));
            cw[5*r+4] = (c == 5) ? 12'd0 : 12'(int'($urandom_range(0, 16)) - 8);
         end
         cw[15] = 12'(int'($urandom_range(0, 200)) - 100);
         cw[16] = 12'($urandom);
         cw[17] = 12'($urandom);
         total += model_leaf(vn);
         send_cls(17);
      end
      thr = total + longint'($urandom_range(0, 2)) - 1;
      sb.push_back('{pass: (total >= thr), sum: 40'(total), err: 1'b0});
      send_thr(36'(thr), 3); wait_sb();

      // asynchronous reset in the middle of LOAD
      stall_en = 1'b0; fixed_lat = 2;
      load_directed();
      do_start(16'd4);
      send_word(cw[0], 1'b0, 1'b0);
      send_word(cw[1], 1'b0, 1'b0);
      send_word(cw[2], 1'b1, 1'b0);
      @(negedge clk_fpga); reset_fpga = 1'b1; #1;
      chk("midrst_err", o_err, 1'b0);
      chk("midrst_ready", o_ready, 1'b0);
      chk("midrst_done", o_done, 1'b0);
      @(posedge clk_fpga); #1; reset_fpga = 1'b0;
      repeat (20) @(posedge clk_fpga);
      @(negedge clk_fpga);
      chk("midrst_idle", o_ready, 1'b0);
      chk("sb_empty", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
